multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//   Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/writeback over one shared memory port.
//   Resolves all six branch conditions, JAL, JALR, LUI, AUIPC. Adds a memory req/ready handshake, illegal-op trap and retire counter.
//   Sits between the instruction register (op, funct3) and the multicycle datapath (ALU flags, muxes, write enables).
// PARAMETERS
//   MEM_HANDSHAKE  1   1: memory states hold until mem_ready; 0: mem_ready ignored (treated as 1)
//   TRAP_HALT      1   1: TRAP is terminal until reset; 0: TRAP lasts 1 cycle, then FETCH
//   CNT_W          32  width of instret_o (wraps modulo 2^CNT_W)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      async active-low reset
//   op         in   7      IR[6:0]
//   funct3     in   3      IR[14:12]
//   Zero       in   1      ALU result == 0
//   ALUR31     in   1      ALU less-than flag (signed or unsigned per funct3)
//   mem_ready  in   1      memory completes the current access this cycle
//   mem_req    out  1      memory access requested
//   MemWrite   out  1      request is a store
//   AdrSrc     out  1      0 = PC, 1 = ALUOut
//   IRWrite    out  1      load IR / OldPC
//   PCWrite    out  1      load PC from Result
//   RegWrite   out  1      register-file write
//   ResultSrc  out  2      00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  2      00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB    out  2      00 rs2, 01 imm, 10 const 4
//   ALUOp      out  2      00 add, 01 sub/compare, 10 decode by funct
//   ImmSrc     out  3      000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
//   trap_o     out  1      high while in TRAP
//   instret_o  out  CNT_W  retired-instruction count
//   state_o    out  4      current state encoding, for debug
// BEHAVIOUR
//   States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9 JAL=10 JALR=11 JALR2=12 UTYPE=13 TRAP=14.
//   Reset: state=FETCH, instret_o=0. While rst_n=0, all strobes (mem_req, MemWrite, IRWrite, PCWrite, RegWrite, trap_o) are 0.
//   Outputs are Moore (state only), except that IRWrite/PCWrite in FETCH and the memory-stage advance are qualified by mem_ready.
//   FETCH:    mem_req, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10; on ready: IRWrite=PCWrite=1, go to DECODE; else hold.
//   DECODE:   A=01, B=01, ALUOp=00 (branch/JAL target into ALUOut). Next state by op:
//             0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH;
//             1101111 -> JAL; 1100111 -> JALR; 0110111/0010111 -> UTYPE; any other op -> TRAP.
//   MEMADR:   A=10, B=01, ALUOp=00; next MEMREAD (load) or MEMWRITE (store).
//   MEMREAD:  mem_req, AdrSrc=1, ResultSrc=00; hold until ready, then MEMWB.
//   MEMWB:    ResultSrc=01, RegWrite; retire; next FETCH.
//   MEMWRITE: mem_req, MemWrite, AdrSrc=1; hold until ready; retire; next FETCH.
//   EXECR:    A=10, B=00, ALUOp=10; next ALUWB.
//   EXECI:    A=10, B=01, ALUOp=10; next ALUWB.
//   ALUWB:    ResultSrc=00, RegWrite; retire; next FETCH.
//   BRANCH:   A=10, B=00, ALUOp=01, ResultSrc=00; PCWrite=take; retire; next FETCH.
//             take: 000 Zero; 001 !Zero; 100/110 ALUR31; 101/111 !ALUR31; 010/011 never taken.
//   JAL:      A=01, B=10, ALUOp=00, ResultSrc=00, PCWrite; next ALUWB (rd=OldPC+4).
//   JALR:     A=10, B=01, ALUOp=00 (target into ALUOut); next JALR2.
//   JALR2:    A=01, B=10, ResultSrc=00, PCWrite; next ALUWB.
//   UTYPE:    A=11 (LUI) or 01 (AUIPC), B=01, ALUOp=00; next ALUWB.
//   TRAP:     trap_o=1, no strobes; TRAP_HALT=1 stays in TRAP; TRAP_HALT=0 goes to FETCH next cycle. No retire.
//   Unlisted outputs in each state are 0 (strobes) or 00 (selects).
//   instret_o increments by exactly 1 on the final cycle of each instruction: MEMWB, MEMWRITE+ready, ALUWB, BRANCH.
//   MEM_HANDSHAKE=0: every memory state takes exactly 1 cycle.
//   rst_n asserted mid-instruction: immediate return to FETCH, no partial write strobes.
// TESTING
//   add (op 0110011), mem_ready=1: FETCH,DECODE,EXECR,ALUWB over 4 cycles; RegWrite only in ALUWB; instret 0->1.
//   lw, mem_ready low 3 cycles in FETCH and 2 in MEMREAD: states hold, IRWrite 1 cycle only; total 10 cycles.
//   beq Zero=1 -> PCWrite=1; bne Zero=1 -> PCWrite=0; bltu ALUR31=1 -> 1; bge ALUR31=1 -> 0; funct3=010 -> 0.
//   jalr: JALR,JALR2,ALUWB sequence; PCWrite only in JALR2; RegWrite only in ALUWB.
//   op=7'b1111111: TRAP, trap_o=1; TRAP_HALT=1 holds 20 cycles; TRAP_HALT=0 returns to FETCH after 1; instret unchanged.
//   rst_n low in MEMWRITE while mem_ready=0: MemWrite/mem_req drop asynchronously; state_o=0 after release.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multicycle RV32I control unit. A Moore FSM sequences
//                fetch / decode / execute / writeback over one shared memory
//                port with a req/ready handshake. It resolves all six branch
//                conditions as well as JAL, JALR, LUI and AUIPC. Illegal
//                opcodes enter a trap state, and a counter tracks retired
//                instructions.
//  Parameters  : MEM_HANDSHAKE 1: memory states wait for mem_ready
//                              0: mem_ready is ignored
//                TRAP_HALT     1: TRAP holds until reset
//                              0: TRAP lasts one cycle, then FETCH
//                CNT_W         width of instret_o (wraps)
//  Ports       : clk, rst_n (async, active low)
//                op, funct3          - from the instruction register
//                Zero, ALUR31        - ALU flags
//                mem_ready, mem_req, MemWrite, AdrSrc - memory port
//                IRWrite, PCWrite, RegWrite            - datapath enables
//                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc - datapath selects
//                trap_o, instret_o, state_o            - status / debug
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TRAP_HALT     = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             Zero,
    input  logic             ALUR31,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             trap_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_UTYPE    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0]       c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]       c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]       c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]       c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0]       c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]       c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]       c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]       c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]       c_OP_AUIPC  = 7'b0010111;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_instret;
    logic             w_ready;
    logic             w_take;
    logic             w_retire;
    logic             w_memReq;
    logic             w_memWrite;
    logic             w_irWrite;
    logic             w_pcWrite;
    logic             w_regWrite;
    logic             w_trap;

    // Without the handshake every memory access completes in one cycle.
    assign w_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Branch resolution. The ALU performs a subtract for the compare, so
    // Zero means equal and ALUR31 means less-than (signed or unsigned,
    // chosen by the datapath from funct3).
    always_comb begin
        w_take = 1'b0;
        case (funct3)
            3'b000:         w_take = Zero;
            3'b001:         w_take = ~Zero;
            3'b100, 3'b110: w_take = ALUR31;
            3'b101, 3'b111: w_take = ~ALUR31;
            default:        w_take = 1'b0;
        endcase
    end

    // Immediate format depends only on the opcode in the IR.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            c_OP_STORE:           ImmSrc = 3'b001;
            c_OP_BRANCH:          ImmSrc = 3'b010;
            c_OP_JAL:             ImmSrc = 3'b011;
            c_OP_LUI, c_OP_AUIPC: ImmSrc = 3'b100;
            default:              ImmSrc = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_retire) begin
                r_instret <= r_instret + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_memReq    = 1'b0;
        w_memWrite  = 1'b0;
        w_irWrite   = 1'b0;
        w_pcWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_trap      = 1'b0;
        w_retire    = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;

        case (r_state)
            S_FETCH: begin
                // PC+4 is computed while the instruction is fetched.
                w_memReq  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (w_ready) begin
                    w_irWrite   = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch/JAL target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_nextState = S_MEMADR;
                    c_OP_RTYPE:            w_nextState = S_EXECR;
                    c_OP_ITYPE:            w_nextState = S_EXECI;
                    c_OP_BRANCH:           w_nextState = S_BRANCH;
                    c_OP_JAL:              w_nextState = S_JAL;
                    c_OP_JALR:             w_nextState = S_JALR;
                    c_OP_LUI, c_OP_AUIPC:  w_nextState = S_UTYPE;
                    default:               w_nextState = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                // Only loads and stores get here; op[5] separates them.
                w_nextState = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_memReq = 1'b1;
                AdrSrc   = 1'b1;
                if (w_ready) begin
                    w_nextState = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_regWrite  = 1'b1;
                w_retire    = 1'b1;
                w_nextState = S_FETCH;
            end
            S_MEMWRITE: begin
                w_memReq   = 1'b1;
                w_memWrite = 1'b1;
                AdrSrc     = 1'b1;
                if (w_ready) begin
                    w_retire    = 1'b1;
                    w_nextState = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA     = 2'b10;
                ALUOp       = 2'b10;
                w_nextState = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                ALUOp       = 2'b10;
                w_nextState = S_ALUWB;
            end
            S_ALUWB: begin
                w_regWrite  = 1'b1;
                w_retire    = 1'b1;
                w_nextState = S_FETCH;
            end
            S_BRANCH: begin
                // Target already sits in ALUOut from DECODE.
                ALUSrcA     = 2'b10;
                ALUOp       = 2'b01;
                w_pcWrite   = w_take;
                w_retire    = 1'b1;
                w_nextState = S_FETCH;
            end
            S_JAL: begin
                // PC <- target in ALUOut while OldPC+4 is formed for rd.
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pcWrite   = 1'b1;
                w_nextState = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                w_nextState = S_JALR2;
            end
            S_JALR2: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pcWrite   = 1'b1;
                w_nextState = S_ALUWB;
            end
            S_UTYPE: begin
                // LUI adds the immediate to zero, AUIPC to OldPC.
                ALUSrcA     = (op == c_OP_LUI) ? 2'b11 : 2'b01;
                ALUSrcB     = 2'b01;
                w_nextState = S_ALUWB;
            end
            S_TRAP: begin
                w_trap = 1'b1;
                if (TRAP_HALT == 0) begin
                    w_nextState = S_FETCH;
                end
            end
            default: begin
                w_nextState = S_FETCH;
            end
        endcase
    end

    // Reset masks the strobes combinationally so nothing is written while
    // rst_n is low, even though the reset state (FETCH) requests memory.
    assign mem_req   = rst_n & w_memReq;
    assign MemWrite  = rst_n & w_memWrite;
    assign IRWrite   = rst_n & w_irWrite;
    assign PCWrite   = rst_n & w_pcWrite;
    assign RegWrite  = rst_n & w_regWrite;
    assign trap_o    = rst_n & w_trap;
    assign instret_o = r_instret;
    assign state_o   = r_state;

endmodule
`default_nettype wire
